// File: rtl/hub75_rx_capture.sv
// HUB75 panel-side receiver: oversamples the bus, rebuilds each shifted line and drains it as per-column beats.
// Define HUB75_RX_SYNC_EN to place a 2-flop synchroniser ahead of the sample stage.
module hub75_rx_capture #(
   parameter int unsigned hpixel_p = 64,
   parameter int unsigned vpixel_p = 32,
   parameter int unsigned bpp_p    = 8
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   O_CLK,
   input  logic                                   STB,
   input  logic                                   A,
   input  logic                                   B,
   input  logic                                   C,
   input  logic                                   D,
   input  logic                                   R1,
   input  logic                                   G1,
   input  logic                                   B1,
   input  logic                                   R2,
   input  logic                                   G2,
   input  logic                                   B2,
   output logic                                   o_px_valid,
   input  logic                                   i_px_ready,
   output logic [$clog2(hpixel_p*vpixel_p/2)-1:0] o_px_addr,
   output logic [5:0]                             o_px_data,
   output logic [$clog2(bpp_p)-1:0]               o_px_plane,
   output logic                                   o_overrun,
   output logic                                   o_len_err
);

   localparam int unsigned aw   = $clog2(hpixel_p*vpixel_p/2);
   localparam int unsigned pw   = $clog2(bpp_p);
   localparam int unsigned colw = $clog2(hpixel_p);
   localparam int unsigned cntw = colw + 1;
   localparam int unsigned in_w = 12;
   localparam int unsigned clk_b = 11;
   localparam int unsigned stb_b = 10;

   typedef enum logic {S_IDLE, S_DRAIN} state_t;

   logic [in_w-1:0] pins;
   logic [in_w-1:0] smp;
   assign pins = {O_CLK, STB, D, C, B, A, R1, G1, B1, R2, G2, B2};

`ifdef HUB75_RX_SYNC_EN
   logic [in_w-1:0] sync1;
   logic [in_w-1:0] sync2;
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         smp   <= '0;
      end else begin
         sync1 <= pins;
         sync2 <= sync1;
         smp   <= sync2;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) smp <= '0;
      else     smp <= pins;
   end
`endif

   logic                      prev_clk;
   logic                      prev_stb;
   logic                      sclk_rise;
   logic                      stb_rise;
   logic [3:0]                smp_row;
   logic [hpixel_p-1:0][5:0]  shift_q;
   logic [hpixel_p-1:0][5:0]  shift_d;
   logic [hpixel_p-1:0][5:0]  drain_q;
   logic [cntw-1:0]           cnt_q;
   logic [cntw-1:0]           cnt_d;
   logic                      ovf_q;
   logic                      ovf_d;
   logic [colw-1:0]           col_q;
   logic [colw-1:0]           col_nx;
   logic [3:0]                last_row;
   logic                      row_vld;
   logic [pw-1:0]             plane_nx;
   logic                      len_ok;
   logic                      last_hs;
   logic                      busy;
   logic                      accept;
   state_t                    state;

   assign sclk_rise = smp[clk_b] & ~prev_clk;
   assign stb_rise  = smp[stb_b] & ~prev_stb;
   assign smp_row   = smp[9:6];
   assign col_nx    = col_q + colw'(1);

   // Shift is applied before the latch looks at the counter, so simultaneous edges see the new count.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (sclk_rise) begin
         if (cnt_q == cntw'(hpixel_p)) begin
            ovf_d = 1'b1;
         end else begin
            shift_d = {shift_q[hpixel_p-2:0], smp[5:0]};
            cnt_d   = cnt_q + cntw'(1);
         end
      end
   end

   always_comb begin
      plane_nx = '0;
      if (row_vld && (smp_row == last_row))
         plane_nx = (o_px_plane == pw'(bpp_p-1)) ? o_px_plane : o_px_plane + pw'(1);
   end

   // A latch coinciding with the final handshake finds the drain buffer free.
   assign len_ok  = !ovf_d && (cnt_d == cntw'(hpixel_p));
   assign last_hs = (state == S_DRAIN) && o_px_valid && i_px_ready && (col_q == colw'(hpixel_p-1));
   assign busy    = (state == S_DRAIN) && !last_hs;
   assign accept  = stb_rise && len_ok && !busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_clk   <= 1'b0;
         prev_stb   <= 1'b0;
         shift_q    <= '0;
         drain_q    <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         col_q      <= '0;
         last_row   <= '0;
         row_vld    <= 1'b0;
         state      <= S_IDLE;
         o_px_valid <= 1'b0;
         o_px_addr  <= '0;
         o_px_data  <= '0;
         o_px_plane <= '0;
         o_overrun  <= 1'b0;
         o_len_err  <= 1'b0;
      end else begin
         prev_clk  <= smp[clk_b];
         prev_stb  <= smp[stb_b];
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         o_overrun <= 1'b0;
         o_len_err <= 1'b0;
         if (stb_rise) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            if (!len_ok)   o_len_err <= 1'b1;
            else if (busy) o_overrun <= 1'b1;
         end
         if (accept) begin
            drain_q    <= shift_d;
            state      <= S_DRAIN;
            o_px_valid <= 1'b1;
            col_q      <= '0;
            o_px_addr  <= aw'(smp_row) << colw;
            o_px_data  <= shift_d[0];
            o_px_plane <= plane_nx;
            last_row   <= smp_row;
            row_vld    <= 1'b1;
         end else if ((state == S_DRAIN) && o_px_valid && i_px_ready) begin
            if (col_q == colw'(hpixel_p-1)) begin
               state      <= S_IDLE;
               o_px_valid <= 1'b0;
            end else begin
               col_q     <= col_nx;
               o_px_addr <= o_px_addr + aw'(1);
               o_px_data <= drain_q[col_nx];
            end
         end
      end
   end

endmodule

// File: tb/tb_hub75_rx_capture.sv
// Bench for hub75_rx_capture: drives HUB75 lines and checks the drained beats against a line-level model.
module tb_hub75_rx_capture;

   localparam int HP  = 64;
   localparam int BPP = 8;

   logic clk = 1'b0;
   logic rst;
   logic O_CLK, STB, A, B, C, D, R1, G1, B1, R2, G2, B2;
   logic i_px_ready;
   logic o_px_valid;
   logic [9:0] o_px_addr;
   logic [5:0] o_px_data;
   logic [2:0] o_px_plane;
   logic o_overrun, o_len_err;

   hub75_rx_capture #(.hpixel_p(HP), .vpixel_p(32), .bpp_p(BPP)) dut (
      .clk(clk), .rst(rst), .O_CLK(O_CLK), .STB(STB),
      .A(A), .B(B), .C(C), .D(D),
      .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
      .o_px_valid(o_px_valid), .i_px_ready(i_px_ready),
      .o_px_addr(o_px_addr), .o_px_data(o_px_data), .o_px_plane(o_px_plane),
      .o_overrun(o_overrun), .o_len_err(o_len_err)
   );

   always #5 clk = ~clk;

   typedef struct { int addr; int data; int plane; } beat_t;
   beat_t exp_q[$];

   int tests = 0, fails = 0;
   int obs_len = 0, obs_ovr = 0, obs_beats = 0;
   int exp_len = 0, exp_ovr = 0, exp_beats = 0;
   int m_prev_row = -1, m_plane = 0;
   logic [5:0] lv [70];
   bit stall_prev = 0;
   int pa, pd, pp;

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Line-level model: a latch either errors, overruns, or yields HP beats in column order.
   task automatic model_latch(input int n, input int row, input bit busy);
      if (n != HP) exp_len++;
      else if (busy) exp_ovr++;
      else begin
         if (m_prev_row == row) m_plane = (m_plane < BPP-1) ? m_plane + 1 : m_plane;
         else m_plane = 0;
         m_prev_row = row;
         for (int col = 0; col < HP; col++)
            exp_q.push_back('{addr: row*HP + col, data: int'(lv[HP-1-col]), plane: m_plane});
         exp_beats += HP;
      end
   endtask

   always @(negedge clk) begin
      if (rst) stall_prev = 0;
      else begin
         if (o_overrun) obs_ovr++;
         if (o_len_err) obs_len++;
         if (stall_prev) begin
            chk("stall_valid", int'(o_px_valid), 1);
            chk("stall_addr", int'(o_px_addr), pa);
            chk("stall_data", int'(o_px_data), pd);
            chk("stall_plane", int'(o_px_plane), pp);
         end
         if (o_px_valid && i_px_ready) begin
            beat_t e;
            obs_beats++;
            chk("beat_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("beat_addr", int'(o_px_addr), e.addr);
               chk("beat_data", int'(o_px_data), e.data);
               chk("beat_plane", int'(o_px_plane), e.plane);
            end
         end
         stall_prev = o_px_valid && !i_px_ready;
         pa = int'(o_px_addr); pd = int'(o_px_data); pp = int'(o_px_plane);
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic shift_bit(input logic [5:0] v);
      {R1, G1, B1, R2, G2, B2} = v;
      O_CLK = 1'b0; step(); step();
      O_CLK = 1'b1; step(); step();
   endtask

   task automatic send_line(input int n, input int row);
      for (int i = 0; i < n; i++) shift_bit(lv[i]);
      {D, C, B, A} = 4'(row);
      O_CLK = 1'b0; step(); step();
      STB = 1'b1; step(); step();
      STB = 1'b0;
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 70; i++) lv[i] = 6'($urandom);
   endtask

   task automatic wait_idle(input bit rnd);
      int k = 0;
      while ((exp_q.size() != 0 || o_px_valid) && k < 4000) begin
         step();
         if (rnd) i_px_ready = 1'($urandom_range(0, 1));
         k++;
      end
      i_px_ready = 1'b1;
      chk("drain_timeout", int'(k < 4000), 1);
      repeat (3) step();
   endtask

   task automatic line(input int n, input int row, input bit rnd);
      model_latch(n, row, 1'b0);
      send_line(n, row);
      wait_idle(rnd);
   endtask

   initial begin
      {O_CLK, STB, A, B, C, D, R1, G1, B1, R2, G2, B2} = '0;
      i_px_ready = 1'b1;
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", int'(o_px_valid), 0);
      chk("rst_addr", int'(o_px_addr), 0);
      chk("rst_data", int'(o_px_data), 0);
      chk("rst_plane", int'(o_px_plane), 0);
      chk("rst_overrun", int'(o_overrun), 0);
      chk("rst_len_err", int'(o_len_err), 0);

      // Ramp line on row 5: column c carries 63-c.
      for (int i = 0; i < 70; i++) lv[i] = 6'(i);
      line(HP, 5, 1'b0);
      chk("ramp_len_err", obs_len, 0);
      chk("ramp_overrun", obs_ovr, 0);

      // Repeated rows advance the plane, a new row resets it, repeats saturate.
      for (int k = 0; k < 3; k++) begin fill_rand(); line(HP, 5, 1'b0); end
      fill_rand(); line(HP, 6, 1'b0);
      for (int k = 0; k < 10; k++) begin fill_rand(); line(HP, 9, 1'b1); end

      // Short and long lines are dropped; the next good line drains normally.
      fill_rand(); line(HP-1, 2, 1'b0);
      chk("short_len_err", obs_len, exp_len);
      fill_rand(); line(HP+1, 3, 1'b0);
      chk("long_len_err", obs_len, exp_len);
      fill_rand(); line(HP, 11, 1'b0);
      chk("after_err_len", obs_len, exp_len);

      // Second latch while the first line is stalled is an overrun.
      i_px_ready = 1'b0;
      fill_rand(); model_latch(HP, 12, 1'b0); send_line(HP, 12);
      fill_rand(); model_latch(HP, 13, 1'b1); send_line(HP, 13);
      repeat (3) step();
      chk("overrun_cnt", obs_ovr, exp_ovr);
      chk("overrun_pending", exp_q.size(), HP);
      i_px_ready = 1'b1;
      wait_idle(1'b0);

      // Random rows with random back-pressure.
      for (int k = 0; k < 5; k++) begin
         int row;
         row = ($urandom_range(0, 1) != 0 && m_prev_row >= 0) ? m_prev_row : int'($urandom_range(0, 15));
         fill_rand();
         line(HP, row, 1'b1);
      end

      // Reset mid-drain abandons the line and restarts plane tracking.
      fill_rand(); line(HP, 7, 1'b0);
      fill_rand(); model_latch(HP, 7, 1'b0); send_line(HP, 7);
      repeat (10) step();
      rst = 1'b1; step(); rst = 1'b0;
      @(negedge clk);
      chk("midrst_valid", int'(o_px_valid), 0);
      chk("midrst_addr", int'(o_px_addr), 0);
      exp_beats -= exp_q.size();
      exp_q.delete();
      m_prev_row = -1; m_plane = 0;
      step();
      fill_rand(); line(HP, 7, 1'b0);

      chk("len_err_total", obs_len, exp_len);
      chk("overrun_total", obs_ovr, exp_ovr);
      chk("beats_total", obs_beats, exp_beats);
      chk("queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
